memory_port_arbiter: RTL and testbench
======================================

Name: memory_port_arbiter

Overview:
Shares the multicycle core's single memory port between two requesters: instruction fetch (port I, driven in FETCH) and data access (port D, driven in MEMREAD/MEMWRITE). Round-robin arbitration, registered request forwarding to memory, one-cycle response pulses, and a per-transaction timeout that aborts a hung memory. Sits between the control unit/datapath and the memory model.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
TIMEOUT, 64, max BUSY cycles waiting for mem_ack; 0 disables timeout

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_req  input  1  fetch request, held high until i_ack
i_addr  input  ADDR_WIDTH  fetch address
i_rdata  output  DATA_WIDTH  fetch read data, valid when i_ack=1
i_ack  output  1  one-cycle fetch completion pulse
i_err  output  1  one-cycle pulse with i_ack on timeout
d_req  input  1  data request, held high until d_ack
d_we  input  1  1=write, 0=read
d_addr  input  ADDR_WIDTH  data address
d_wdata  input  DATA_WIDTH  write data
d_rdata  output  DATA_WIDTH  data read data, valid when d_ack=1
d_ack  output  1  one-cycle data completion pulse
d_err  output  1  one-cycle pulse with d_ack on timeout
mem_req  output  1  memory request, held until mem_ack or timeout
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_ack
mem_ack  input  1  memory completion, sampled only in BUSY
busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs registered. Reset (async, rst_n=0): state=IDLE, all outputs 0, last_grant=D (so first tie goes to I), timeout counter 0.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: only I requesting -> grant I; only D -> grant D; both -> grant port != last_grant. On grant: latch addr (and we/wdata for D; mem_we=0 for I) into mem_* regs, set mem_req=1, update last_grant, clear counter, go BUSY_x. No request -> stay, mem_req=0.
- BUSY_x: mem_req/mem_we/mem_addr/mem_wdata held stable. mem_ack=1 -> capture mem_rdata into x_rdata (writes capture too; value don't-care), mem_req=0, x_ack=1 next cycle, go RESP. Else counter++; with TIMEOUT>0 and counter reaching TIMEOUT-1 with no ack -> mem_req=0, x_rdata=0, x_ack=1 and x_err=1 next cycle, go RESP.
- Minimum latency: req sampled in IDLE at cycle T -> mem_req high T+1 -> mem_ack at T+1 -> x_ack at T+2 -> IDLE at T+3.
- RESP: x_ack (and x_err if timeout) high exactly this one cycle; requests ignored; go IDLE. Requester must drop req by the IDLE cycle after ack or it is re-granted as a new transaction.
- x_rdata holds its value until the next completion on that port.
- mem_ack in IDLE/RESP ignored. mem_ack and timeout in same cycle: ack wins, no err.
- Requester dropping req during BUSY: transaction still completes, ack still pulsed.
- Address/data changes on requester inputs after grant have no effect.
- Reset mid-transaction: immediate return to IDLE, mem_req=0, no ack/err pulse.
- busy=1 in BUSY_I, BUSY_D, RESP.
- Never more than one outstanding memory transaction; i_ack and d_ack never high together.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, memory acks 1st BUSY cycle with 0x00500093 -> mem_req high 1 cycle, mem_we=0, i_ack at T+2, i_rdata=0x00500093, i_err=0.
- Tie after reset: i_req and d_req rise together (d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF) -> I served first, then D with mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF; next tie serves D first.
- Wait states: memory acks after 5 cycles -> mem_req high 5 cycles, signals stable, d_ack exactly one cycle after ack sample, single pulse.
- Timeout (TIMEOUT=8), memory never acks -> mem_req drops after 8 BUSY cycles, d_ack=d_err=1 for one cycle, d_rdata=0; next request serviced normally.
- Reset mid-BUSY: rst_n low 2 cycles during BUSY_I -> all outputs 0 immediately, no i_ack; after release, tie goes to I.
- Spurious mem_ack=1 in IDLE and RESP -> no ack pulse, no state change.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one memory port between the instruction fetch
// port (I) and the data port (D). It uses round-robin arbitration with
// registered request forwarding and one-cycle completion pulses. A
// per-transaction timeout aborts a memory that never acknowledges.
module memory_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [DATA_WIDTH-1:0] i_rdata,
   output logic                  i_ack,
   output logic                  i_err,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_ack,
   output logic                  d_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic                  busy
);

   // The counter only has to reach TIMEOUT-1, so it is sized for that value.
   localparam int CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int TLAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] TLAST = TLAST_I[CW-1:0];
   localparam bit    TO_EN = (TIMEOUT > 0);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

   state_t                state, state_nx;
   logic                  last_d, last_d_nx;   // 1: last grant went to D
   logic [CW-1:0]         cnt, cnt_nx;
   logic                  grant_i, grant_d, timeout_hit;
   logic                  mem_req_nx, mem_we_nx, busy_nx;
   logic [ADDR_WIDTH-1:0] mem_addr_nx;
   logic [DATA_WIDTH-1:0] mem_wdata_nx, i_rdata_nx, d_rdata_nx;
   logic                  i_ack_nx, i_err_nx, d_ack_nx, d_err_nx;

   // On a tie, the port that was not granted last time wins.
   assign grant_i     = i_req && (!d_req || last_d);
   assign grant_d     = d_req && !grant_i;
   assign timeout_hit = TO_EN && (cnt == TLAST);

   // Next-state and next-output logic. Outputs hold their value by default,
   // and the ack/err pulses default low.
   always_comb begin
      state_nx     = state;
      last_d_nx    = last_d;
      cnt_nx       = cnt;
      mem_req_nx   = mem_req;
      mem_we_nx    = mem_we;
      mem_addr_nx  = mem_addr;
      mem_wdata_nx = mem_wdata;
      i_rdata_nx   = i_rdata;
      d_rdata_nx   = d_rdata;
      i_ack_nx     = 1'b0;
      i_err_nx     = 1'b0;
      d_ack_nx     = 1'b0;
      d_err_nx     = 1'b0;
      case (state)
         IDLE: begin
            mem_req_nx = 1'b0;
            if (grant_i) begin
               mem_req_nx  = 1'b1;
               mem_we_nx   = 1'b0;
               mem_addr_nx = i_addr;
               last_d_nx   = 1'b0;
               cnt_nx      = '0;
               state_nx    = BUSY_I;
            end else if (grant_d) begin
               mem_req_nx   = 1'b1;
               mem_we_nx    = d_we;
               mem_addr_nx  = d_addr;
               mem_wdata_nx = d_wdata;
               last_d_nx    = 1'b1;
               cnt_nx       = '0;
               state_nx     = BUSY_D;
            end
         end
         BUSY_I, BUSY_D: begin
            // If mem_ack and the timeout land in the same cycle, the ack wins.
            if (mem_ack || timeout_hit) begin
               mem_req_nx = 1'b0;
               state_nx   = RESP;
               if (state == BUSY_I) begin
                  i_ack_nx   = 1'b1;
                  i_err_nx   = !mem_ack;
                  i_rdata_nx = mem_ack ? mem_rdata : '0;
               end else begin
                  d_ack_nx   = 1'b1;
                  d_err_nx   = !mem_ack;
                  d_rdata_nx = mem_ack ? mem_rdata : '0;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         RESP: begin
            mem_req_nx = 1'b0;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx != IDLE);
   end

   // State and output registers. Reset leaves last_d set, so I wins the
   // first tie after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_d    <= 1'b1;
         cnt       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_ack     <= 1'b0;
         i_err     <= 1'b0;
         d_ack     <= 1'b0;
         d_err     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         last_d    <= last_d_nx;
         cnt       <= cnt_nx;
         mem_req   <= mem_req_nx;
         mem_we    <= mem_we_nx;
         mem_addr  <= mem_addr_nx;
         mem_wdata <= mem_wdata_nx;
         i_rdata   <= i_rdata_nx;
         d_rdata   <= d_rdata_nx;
         i_ack     <= i_ack_nx;
         i_err     <= i_err_nx;
         d_ack     <= d_ack_nx;
         d_err     <= d_err_nx;
         busy      <= busy_nx;
      end
   end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Testbench for memory_port_arbiter. A scripted memory model drives the
// memory side. Monitors pop the expected transactions and responses from
// queues and compare them against the DUT outputs.
`timescale 1ns/1ps
module tb_memory_port_arbiter;

   typedef struct {bit d; logic [31:0] rdata; bit err; bit chk;} resp_t;
   typedef struct {bit we; logic [31:0] addr; logic [31:0] wdata; int len;} mexp_t;
   typedef struct {int delay; bit never; logic [31:0] rdata;} mbeh_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic        i_ack, i_err, d_ack, d_err, mem_req, mem_we, busy;

   int    checks = 0;
   int    errors = 0;
   bit    spur = 1'b0;
   logic  samp_req = 1'b0, samp_ack = 1'b0;

   resp_t resp_q[$];
   mexp_t mexp_q[$];
   mbeh_t mbeh_q[$];

   memory_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Memory model: each transaction takes its delay/rdata from mbeh_q.
   // Driven on negedge, so it is stable at the next rising edge.
   initial begin
      int    bcnt;
      mbeh_t cur;
      bcnt = 0;
      cur  = '{1, 1'b1, 32'h0};
      forever begin
         @(negedge clk);
         if (mem_req) begin
            if (bcnt == 0) begin
               if (mbeh_q.size() > 0) cur = mbeh_q.pop_front();
               else cur = '{1, 1'b1, 32'h0};
            end
            bcnt++;
            mem_ack   = !cur.never && (bcnt == cur.delay);
            mem_rdata = cur.rdata;
         end else begin
            bcnt      = 0;
            mem_ack   = spur;
            mem_rdata = 32'hBAD0BAD0;
         end
      end
   end

   // Record what the DUT sampled on each rising edge.
   initial forever begin
      @(posedge clk);
      samp_req = mem_req;
      samp_ack = mem_ack;
   end

   // Memory-side monitor: request contents, hold length and stability.
   initial begin
      logic  prev;
      mexp_t e;
      int    len;
      bit    unstable;
      logic  cwe;
      logic [31:0] caddr, cwdata;
      prev = 1'b0; len = 0; unstable = 1'b0; cwe = 1'b0; caddr = '0; cwdata = '0;
      e = '{1'b0, 32'h0, 32'h0, 0};
      forever begin
         @(negedge clk);
         if (mem_req && !prev) begin
            if (mexp_q.size() == 0) begin
               e = '{mem_we, mem_addr, mem_wdata, 0};
               check("mem_unexpected_req", 32'd1, 32'd0);
            end else begin
               e = mexp_q.pop_front();
               check("mem_we", {31'b0, mem_we}, {31'b0, e.we});
               check("mem_addr", mem_addr, e.addr);
               if (e.we) check("mem_wdata", mem_wdata, e.wdata);
            end
            cwe = mem_we; caddr = mem_addr; cwdata = mem_wdata;
            len = 1; unstable = 1'b0;
         end else if (mem_req) begin
            len++;
            if (mem_we !== cwe || mem_addr !== caddr || mem_wdata !== cwdata) unstable = 1'b1;
         end else if (prev) begin
            check("mem_req_len", len, e.len);
            check("mem_stable", {31'b0, unstable}, 32'd0);
         end
         prev = mem_req;
      end
   end

   // Response monitor: pops the scoreboard on every ack pulse.
   initial forever begin
      @(negedge clk);
      if (i_ack && d_ack) check("both_acks", 32'd1, 32'd0);
      if (i_err && !i_ack) check("i_err_alone", 32'd1, 32'd0);
      if (d_err && !d_ack) check("d_err_alone", 32'd1, 32'd0);
      for (int p = 0; p < 2; p++) begin
         logic  ack, err;
         logic [31:0] rd;
         resp_t e;
         ack = (p == 0) ? i_ack : d_ack;
         err = (p == 0) ? i_err : d_err;
         rd  = (p == 0) ? i_rdata : d_rdata;
         if (ack) begin
            if (resp_q.size() == 0) begin
               check(p == 0 ? "i_ack_unexpected" : "d_ack_unexpected", 32'd1, 32'd0);
            end else begin
               e = resp_q.pop_front();
               check("ack_port", p, {31'b0, e.d});
               check("ack_err", {31'b0, err}, {31'b0, e.err});
               if (e.chk) check("ack_rdata", rd, e.rdata);
               check("ack_busy", {31'b0, busy}, 32'd1);
               check("ack_latency", {31'b0, samp_req && (e.err || samp_ack)}, 32'd1);
            end
         end
      end
   end

   task automatic exp_i(input logic [31:0] addr, input logic [31:0] rdata, input int delay);
      mexp_q.push_back('{1'b0, addr, 32'h0, delay});
      mbeh_q.push_back('{delay, 1'b0, rdata});
      resp_q.push_back('{1'b0, rdata, 1'b0, 1'b1});
   endtask

   task automatic exp_d(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int delay, input bit never);
      mexp_q.push_back('{we, addr, wdata, never ? 8 : delay});
      mbeh_q.push_back('{delay, never, rdata});
      resp_q.push_back('{1'b1, never ? 32'h0 : rdata, never, !we || never});
   endtask

   // Drop each request on its ack; a budget overrun is a failure.
   task automatic run_reqs(input int budget);
      int n;
      n = 0;
      while ((i_req || d_req) && n < budget) begin
         @(negedge clk);
         if (i_ack) i_req = 1'b0;
         if (d_ack) d_req = 1'b0;
         n++;
      end
      if (i_req || d_req) begin
         check("req_completion_timeout", n, budget + 1);
         i_req = 1'b0;
         d_req = 1'b0;
      end
   endtask

   task automatic drive_i(input logic [31:0] addr);
      @(negedge clk);
      i_req = 1'b1; i_addr = addr;
   endtask

   initial begin
      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_acks", {28'b0, i_ack, i_err, d_ack, d_err}, 32'd0);
      check("rst_rdata", i_rdata | d_rdata, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // First tie after reset: I, then the D write.
      exp_i(32'h100, 32'h00500093, 1);
      exp_d(1'b1, 32'h200, 32'hDEADBEEF, 32'h0, 1, 1'b0);
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
      run_reqs(40);

      // Single fetch with a first-cycle ack.
      exp_i(32'h104, 32'h00A00113, 1);
      drive_i(32'h104);
      run_reqs(20);

      // Tie after an I grant: D goes first.
      exp_d(1'b0, 32'h208, 32'h0, 32'h11112222, 2, 1'b0);
      exp_i(32'h108, 32'h33334444, 1);
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h108;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h208;
      run_reqs(40);

      // Wait states. The D inputs are scrambled after the grant.
      exp_d(1'b0, 32'h400, 32'h0, 32'hCAFEF00D, 5, 1'b0);
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
      @(negedge clk);
      d_addr = 32'hFFFF0000; d_wdata = 32'h01234567; d_we = 1'b1;
      run_reqs(30);
      check("i_rdata_hold", i_rdata, 32'h33334444);

      // Timeout: the memory never acks.
      exp_d(1'b0, 32'h500, 32'h0, 32'h0, 1, 1'b1);
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
      run_reqs(30);
      exp_i(32'h600, 32'h12345678, 2);
      drive_i(32'h600);
      run_reqs(20);
      check("d_rdata_hold_after_timeout", d_rdata, 32'h0);

      // Spurious mem_ack in IDLE and in RESP.
      spur = 1'b1;
      repeat (5) @(negedge clk);
      check("spur_idle_mem_req", {31'b0, mem_req}, 32'd0);
      check("spur_idle_busy", {31'b0, busy}, 32'd0);
      exp_i(32'h700, 32'h0BADF00D, 1);
      drive_i(32'h700);
      run_reqs(20);
      repeat (3) @(negedge clk);
      check("spur_after_busy", {31'b0, busy}, 32'd0);
      spur = 1'b0;

      // Reset during BUSY_I: outputs clear at once and no ack follows.
      mexp_q.push_back('{1'b0, 32'h300, 32'h0, 3});
      mbeh_q.push_back('{1, 1'b1, 32'h0});
      drive_i(32'h300);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      i_req = 1'b0;
      #1;
      check("midrst_mem_req", {31'b0, mem_req}, 32'd0);
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_acks", {28'b0, i_ack, i_err, d_ack, d_err}, 32'd0);
      check("midrst_mem_addr", mem_addr, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Tie after the second reset goes to I.
      exp_i(32'h800, 32'h55556666, 1);
      exp_d(1'b0, 32'h900, 32'h0, 32'h77778888, 3, 1'b0);
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h800;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h900;
      run_reqs(40);

      repeat (4) @(negedge clk);
      check("resp_q_empty", resp_q.size(), 32'd0);
      check("mexp_q_empty", mexp_q.size(), 32'd0);
      check("final_busy", {31'b0, busy}, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=expired required=finished");
      $fatal(1, "watchdog");
   end

endmodule
